// File: rtl/proc_sysid_pkg.sv
// Shared register map, CONTROL bit positions and CAPS layout for the
// proc_sysid_ext build-info slave.
package proc_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_VERSION   = 3'd2;
  localparam logic [2:0] ADDR_CAPS      = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd5;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd6;
  localparam logic [2:0] ADDR_CONTROL   = 3'd7;

  localparam int CTRL_CLR    = 0;
  localparam int CTRL_FREEZE = 1;
  localparam int CTRL_OVF    = 2;

  typedef struct packed {
    logic [15:0] reserved;
    logic [7:0]  uptime_w;
    logic [7:0]  addr_w;
  } caps_t;

  function automatic logic [31:0] caps_word(input logic [7:0] uptime_w,
                                            input logic [7:0] addr_w);
    caps_t caps;
    caps.reserved = '0;
    caps.uptime_w = uptime_w;
    caps.addr_w   = addr_w;
    return caps;
  endfunction

endpackage

// File: rtl/proc_sysid_uptime.sv
// Free-running uptime counter with hi-word snapshot, clear, hold and a sticky
// wrap flag.
module proc_sysid_uptime
  import proc_sysid_pkg::*;
#(
  parameter int UPTIME_W = 48
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     freeze,
  input  logic                     ovf_clr,
  input  logic                     snap,
  output logic [UPTIME_W-1:0]      cnt,
  output logic [UPTIME_W-33:0]     snapshot,
  output logic                     ovf
);

  localparam logic [UPTIME_W-1:0] CNT_ONE = UPTIME_W'(1);

  logic [UPTIME_W-1:0]  cnt_q, cnt_d;
  logic [UPTIME_W-33:0] snap_q, snap_d;
  logic                 ovf_q, ovf_d;

  // NOTE: every next-state variable gets its hold value first so no path
  // through this block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    snap_d = snap_q;
    ovf_d  = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    // Snapshot sees the same pre-increment count the LO read returns.
    if (snap) snap_d = cnt_q[UPTIME_W-1:32];
    if (clr) begin
      cnt_d  = '0;
      snap_d = '0;
    end else if (!freeze) begin
      cnt_d = cnt_q + CNT_ONE;
      // Placed after the clear so a wrap in the same edge wins.
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt      = cnt_q;
  assign snapshot = snap_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/proc_sysid_ext.sv
// System-ID / build-info Avalon-MM slave: identity words, scratch register and
// uptime counter behind a one-cycle registered read path.
module proc_sysid_ext
  import proc_sysid_pkg::*;
#(
  parameter logic [31:0] ID        = 32'hAAAA_AAAA,
  parameter logic [31:0] TIMESTAMP = 32'h0,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          ADDR_W    = 3,
  parameter int          UPTIME_W  = 48
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] CAPS = caps_word(8'(UPTIME_W), 8'(ADDR_W));

  logic [7:0]  word_addr;
  logic        in_map;
  logic [2:0]  reg_sel;
  logic        wr_scratch, wr_ctrl;
  logic [31:0] scratch_q, scratch_d;
  logic        freeze_q, freeze_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q;
  logic [31:0] ctrl_word;

  logic [UPTIME_W-1:0]  cnt;
  logic [UPTIME_W-33:0] snapshot;
  logic                 ovf;
  logic                 unused_cnt_hi;

  // Addresses beyond the eight-word map alias nothing: they read 0, ignore writes.
  assign word_addr  = 8'(address);
  assign in_map     = (word_addr[7:3] == 5'd0);
  assign reg_sel    = word_addr[2:0];
  assign wr_scratch = write && in_map && (reg_sel == ADDR_SCRATCH);
  assign wr_ctrl    = write && in_map && (reg_sel == ADDR_CONTROL);

  always_comb begin
    scratch_d = scratch_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_scratch && byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
    end
  end

  assign freeze_d = wr_ctrl ? writedata[CTRL_FREEZE] : freeze_q;

  proc_sysid_uptime #(
    .UPTIME_W (UPTIME_W)
  ) u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (wr_ctrl && writedata[CTRL_CLR]),
    .freeze   (freeze_q),
    .ovf_clr  (wr_ctrl && writedata[CTRL_OVF]),
    .snap     (read && in_map && (reg_sel == ADDR_UPTIME_LO)),
    .cnt      (cnt),
    .snapshot (snapshot),
    .ovf      (ovf)
  );

  assign unused_cnt_hi = ^cnt[UPTIME_W-1:32];

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_FREEZE] = freeze_q;
    ctrl_word[CTRL_OVF]    = ovf;
  end

  // Mux sees pre-write state, so a simultaneous read+write returns the old value.
  always_comb begin
    readdata_d = '0;
    if (in_map) begin
      case (reg_sel)
        ADDR_ID:        readdata_d = ID;
        ADDR_TIMESTAMP: readdata_d = TIMESTAMP;
        ADDR_VERSION:   readdata_d = VERSION;
        ADDR_CAPS:      readdata_d = CAPS;
        ADDR_SCRATCH:   readdata_d = scratch_q;
        ADDR_UPTIME_LO: readdata_d = cnt[31:0];
        ADDR_UPTIME_HI: readdata_d = 32'(snapshot);
        ADDR_CONTROL:   readdata_d = ctrl_word;
        default:        readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= '0;
      freeze_q   <= 1'b0;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      freeze_q  <= freeze_d;
      rvalid_q  <= read;
      if (read) readdata_q <= readdata_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_proc_sysid_ext.sv
// Directed bench for proc_sysid_ext: instance A uses defaults, instance B uses
// ADDR_W=4 / UPTIME_W=33 for the wrap and out-of-map cases. Both share the bus.
module tb_proc_sysid_ext;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata_a, readdata_b;
  logic        readdatavalid_a, readdatavalid_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  proc_sysid_ext dut_a (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address[2:0]),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata_a),
    .readdatavalid (readdatavalid_a)
  );

  proc_sysid_ext #(
    .ADDR_W   (4),
    .UPTIME_W (33)
  ) dut_b (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata_b),
    .readdatavalid (readdatavalid_b)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic rd, input logic wr,
                         input logic [3:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr;
    v.be = be; v.wdata = wdata; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One bus cycle; returns at posedge+1 with the response of this cycle's read visible.
  task automatic bus(input logic rd, input logic wr, input logic [3:0] addr,
                     input logic [3:0] be, input logic [31:0] wd);
    read = rd; write = wr; address = addr; byteenable = be; writedata = wd;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wd);
    bus(1'b0, 1'b1, addr, 4'hF, wd);
  endtask

  task automatic rd_reg(input logic [3:0] addr);
    bus(1'b1, 1'b0, addr, 4'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [31:0] frozen_lo;

  initial begin
    // T1/T2 plus read-while-write, RO-write and CONTROL round trips on instance A.
    add_vec("t1_id",        1, 0, 4'd0, 4'h0, 32'h0,         32'hAAAA_AAAA);
    add_vec("t1_timestamp", 1, 0, 4'd1, 4'h0, 32'h0,         32'h0000_0000);
    add_vec("t1_version",   1, 0, 4'd2, 4'h0, 32'h0,         32'h0001_0000);
    add_vec("t1_caps",      1, 0, 4'd3, 4'h0, 32'h0,         32'h0000_3003);
    add_vec("t2_wr_full",   0, 1, 4'd4, 4'hF, 32'hDEAD_BEEF, 32'h0);
    add_vec("t2_wr_be0101", 0, 1, 4'd4, 4'h5, 32'h0000_0000, 32'h0);
    add_vec("t2_scratch",   1, 0, 4'd4, 4'h0, 32'h0,         32'hDE00_BE00);
    add_vec("rw_old_value", 1, 1, 4'd4, 4'hF, 32'h1234_5678, 32'hDE00_BE00);
    add_vec("rw_new_value", 1, 0, 4'd4, 4'h0, 32'h0,         32'h1234_5678);
    add_vec("ro_id_write",  0, 1, 4'd0, 4'hF, 32'h0,         32'h0);
    add_vec("ro_id_keep",   1, 0, 4'd0, 4'h0, 32'h0,         32'hAAAA_AAAA);
    add_vec("ctrl_reset",   1, 0, 4'd7, 4'h0, 32'h0,         32'h0000_0000);
    add_vec("hi_reset",     1, 0, 4'd6, 4'h0, 32'h0,         32'h0000_0000);
    add_vec("ctrl_frz_wr",  0, 1, 4'd7, 4'hF, 32'h2,         32'h0);
    add_vec("ctrl_frz_rd",  1, 0, 4'd7, 4'h0, 32'h0,         32'h0000_0002);
    add_vec("ctrl_run_wr",  0, 1, 4'd7, 4'hF, 32'h0,         32'h0);
    add_vec("ctrl_run_rd",  1, 0, 4'd7, 4'h0, 32'h0,         32'h0000_0000);

    repeat (3) @(posedge clock);
    #1;
    check("reset_readdata", readdata_a, 32'h0);
    check("reset_rvalid", 32'(readdatavalid_a), 32'h0);
    reset_n = 1'b1;
    idle(1);

    foreach (vecs[i]) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      check({vecs[i].name, "_valid"}, 32'(readdatavalid_a), 32'(vecs[i].rd));
      if (vecs[i].rd) check(vecs[i].name, readdata_a, vecs[i].exp);
    end
    idle(1);
    check("idle_rvalid", 32'(readdatavalid_a), 32'h0);

    // T3: FREEZE holds the counter; releasing it gives exactly five increments.
    wr_reg(4'd7, 32'h2);
    rd_reg(4'd5);
    frozen_lo = readdata_a;
    idle(10);
    rd_reg(4'd5);
    check("t3_frozen_equal", readdata_a, frozen_lo);
    wr_reg(4'd7, 32'h0);
    idle(5);
    rd_reg(4'd5);
    check("t3_advance", readdata_a, frozen_lo + 32'd5);

    // T5 on A: CLR zeroes the count and reads back as 0.
    wr_reg(4'd7, 32'h1);
    rd_reg(4'd5);
    check("t5_lo_lt4", 32'(readdata_a < 32'd4), 32'h1);
    rd_reg(4'd6);
    check("t5_hi_zero", readdata_a, 32'h0);
    rd_reg(4'd7);
    check("t5_ctrl", readdata_a, 32'h0);

    // T6 on B: CAPS, out-of-map reads and writes, RO write.
    rd_reg(4'd3);
    check("b_caps", readdata_b, 32'h0000_2104);
    rd_reg(4'd9);
    check("t6_addr9", readdata_b, 32'h0);
    check("t6_addr9_valid", 32'(readdatavalid_b), 32'h1);
    wr_reg(4'd12, 32'hFFFF_FFFF);
    rd_reg(4'd4);
    check("t6_alias_ignored", readdata_b, 32'h1234_5678);
    wr_reg(4'd0, 32'h1111_1111);
    rd_reg(4'd0);
    check("t6_id_unchanged", readdata_b, 32'hAAAA_AAAA);

    // T4 on B: preload the count at all-ones while frozen, then let it wrap.
    wr_reg(4'd7, 32'h2);
    force dut_b.u_uptime.cnt_q = 33'h1_FFFF_FFFF;
    idle(1);
    release dut_b.u_uptime.cnt_q;
    rd_reg(4'd5);
    check("t4_lo", readdata_b, 32'hFFFF_FFFF);
    rd_reg(4'd6);
    check("t4_hi", readdata_b, 32'h0000_0001);
    wr_reg(4'd7, 32'h0);
    // Wrap edge also carries OVF-clear and re-freeze: the set must win.
    wr_reg(4'd7, 32'h6);
    rd_reg(4'd5);
    check("t4_wrap_lo", readdata_b, 32'h0);
    rd_reg(4'd6);
    check("t4_wrap_hi", readdata_b, 32'h0);
    rd_reg(4'd7);
    check("t4_ovf_set", readdata_b, 32'h0000_0006);

    // CLR beats FREEZE, clears the snapshot, keeps OVF.
    force dut_b.u_uptime.cnt_q = 33'h1_0000_0005;
    idle(1);
    release dut_b.u_uptime.cnt_q;
    rd_reg(4'd5);
    check("clr_pre_lo", readdata_b, 32'h0000_0005);
    rd_reg(4'd6);
    check("clr_pre_hi", readdata_b, 32'h0000_0001);
    wr_reg(4'd7, 32'h3);
    rd_reg(4'd6);
    check("clr_snapshot", readdata_b, 32'h0);
    rd_reg(4'd5);
    check("clr_lo", readdata_b, 32'h0);
    rd_reg(4'd7);
    check("clr_keeps_ovf", readdata_b, 32'h0000_0006);
    wr_reg(4'd7, 32'h4);
    rd_reg(4'd7);
    check("t4_ovf_clear", readdata_b, 32'h0);

    // T6: reset in the cycle after a read drops the pending valid at once.
    bus(1'b1, 1'b0, 4'd0, 4'h0, 32'h0);
    check("rst_pre_valid", 32'(readdatavalid_a), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_valid_a", 32'(readdatavalid_a), 32'h0);
    check("rst_valid_b", 32'(readdatavalid_b), 32'h0);
    check("rst_readdata", readdata_a, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    rd_reg(4'd4);
    check("rst_scratch", readdata_a, 32'h0);
    rd_reg(4'd7);
    check("rst_ctrl_b", readdata_b, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
